// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage MIPS hazard unit (Tuse/Tnew stalls, D/E forwarding selects, HI/LO busy countdown).
// Latency: stall/enable/forward outputs are combinational same-cycle; md_busy is registered (start at t -> busy t+1..t+LAT).
// Backpressure: a stall drops en_PC/en_D and raises clr_E so a bubble enters E; optional HAZARD_STALL_CNT_EN adds stall_cnt.
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    // D stage sources
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [2:0]  tuse_rs_D,
    input  logic [2:0]  tuse_rt_D,
    input  logic        md_use_D,
    // E stage
    input  logic        rfwe_E,
    input  logic [4:0]  writeaddr_E,
    input  logic [2:0]  tnew_E,
    input  logic [4:0]  read1addr_E,
    input  logic [4:0]  read2addr_E,
    input  logic        md_start_E,
    input  logic        md_div_E,
    // M stage
    input  logic        rfwe_M,
    input  logic [4:0]  writeaddr_M,
    input  logic [2:0]  tnew_M,
    // W stage
    input  logic        rfwe_W,
    input  logic [4:0]  writeaddr_W,
    // controls
    output logic        en_PC,
    output logic        en_D,
    output logic        clr_E,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_a_E,
    output logic [1:0]  fwd_b_E,
    output logic        md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    // Countdown load values; anything above the 4-bit range is pinned at 15.
    localparam logic [3:0] L_MULT = (MULT_LAT > 15) ? 4'd15 : 4'(MULT_LAT);
    localparam logic [3:0] L_DIV  = (DIV_LAT  > 15) ? 4'd15 : 4'(DIV_LAT);

    // Forwarding select encodings
    localparam logic [1:0] FWD_D_RF = 2'd0;
    localparam logic [1:0] FWD_D_E  = 2'd1;
    localparam logic [1:0] FWD_D_M  = 2'd2;
    localparam logic [1:0] FWD_E_REG = 2'd0;
    localparam logic [1:0] FWD_E_M   = 2'd1;
    localparam logic [1:0] FWD_E_W   = 2'd2;

    // A stage "hits" a source when it writes the RF at that address; $0 is hardwired and never hits.
    function automatic logic f_hit(input logic we, input logic [4:0] wa, input logic [4:0] a);
        return we && (wa == a) && (a != 5'd0);
    endfunction

    logic       w_hit_e_rs;
    logic       w_hit_m_rs;
    logic       w_hit_e_rt;
    logic       w_hit_m_rt;
    logic       w_hit_m_a;
    logic       w_hit_w_a;
    logic       w_hit_m_b;
    logic       w_hit_w_b;
    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall_md;
    logic       w_stall;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    // Address match of every consumer against every in-flight producer
    always_comb begin
        w_hit_e_rs = f_hit(rfwe_E, writeaddr_E, rs_D);
        w_hit_m_rs = f_hit(rfwe_M, writeaddr_M, rs_D);
        w_hit_e_rt = f_hit(rfwe_E, writeaddr_E, rt_D);
        w_hit_m_rt = f_hit(rfwe_M, writeaddr_M, rt_D);
        w_hit_m_a  = f_hit(rfwe_M, writeaddr_M, read1addr_E);
        w_hit_w_a  = f_hit(rfwe_W, writeaddr_W, read1addr_E);
        w_hit_m_b  = f_hit(rfwe_M, writeaddr_M, read2addr_E);
        w_hit_w_b  = f_hit(rfwe_W, writeaddr_W, read2addr_E);
    end

    // Stall when a producer's result arrives later than the D instruction needs it,
    // or when a HI/LO user would race an in-flight or starting mult/div.
    always_comb begin
        w_stall_rs = (w_hit_e_rs && (tuse_rs_D < tnew_E)) ||
                     (w_hit_m_rs && (tuse_rs_D < tnew_M));
        w_stall_rt = (w_hit_e_rt && (tuse_rt_D < tnew_E)) ||
                     (w_hit_m_rt && (tuse_rt_D < tnew_M));
        w_stall_md = md_use_D && (md_start_E || md_busy);
        w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    end

    // Freeze PC and D register and inject a bubble into E on a stall
    always_comb begin
        en_PC = !w_stall;
        en_D  = !w_stall;
        clr_E = w_stall;
    end

    // D-stage bypass: the youngest producer (E) wins; only ready values (tnew==0) are forwarded
    always_comb begin
        fwd_rs_D = FWD_D_RF;
        fwd_rt_D = FWD_D_RF;
        if (w_hit_e_rs && (tnew_E == 3'd0)) begin
            fwd_rs_D = FWD_D_E;
        end else if (w_hit_m_rs && (tnew_M == 3'd0)) begin
            fwd_rs_D = FWD_D_M;
        end
        if (w_hit_e_rt && (tnew_E == 3'd0)) begin
            fwd_rt_D = FWD_D_E;
        end else if (w_hit_m_rt && (tnew_M == 3'd0)) begin
            fwd_rt_D = FWD_D_M;
        end
    end

    // E-stage bypass: M beats W; W data is always final so it needs no Tnew check
    always_comb begin
        fwd_a_E = FWD_E_REG;
        fwd_b_E = FWD_E_REG;
        if (w_hit_m_a && (tnew_M == 3'd0)) begin
            fwd_a_E = FWD_E_M;
        end else if (w_hit_w_a) begin
            fwd_a_E = FWD_E_W;
        end
        if (w_hit_m_b && (tnew_M == 3'd0)) begin
            fwd_b_E = FWD_E_M;
        end else if (w_hit_w_b) begin
            fwd_b_E = FWD_E_W;
        end
    end

    // HI/LO countdown next value: a new start always reloads, otherwise count down to zero
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (md_start_E) begin
            w_cnt_nxt = md_div_E ? L_DIV : L_MULT;
        end else if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
        end
    end

    // HI/LO countdown register; reset beats a simultaneous start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign md_busy = (r_cnt != 4'd0);

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Free-running count of stalled cycles; wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// Latency: expectations are queued when inputs are driven and compared at the following negedge.
// Backpressure: none; one expectation per clock.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D;
    logic [2:0]  tuse_rs_D, tuse_rt_D;
    logic        md_use_D;
    logic        rfwe_E;
    logic [4:0]  writeaddr_E;
    logic [2:0]  tnew_E;
    logic [4:0]  read1addr_E, read2addr_E;
    logic        md_start_E, md_div_E;
    logic        rfwe_M;
    logic [4:0]  writeaddr_M;
    logic [2:0]  tnew_M;
    logic        rfwe_W;
    logic [4:0]  writeaddr_W;
    logic        en_PC, en_D, clr_E;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E;
    logic        md_busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .md_use_D(md_use_D),
        .rfwe_E(rfwe_E), .writeaddr_E(writeaddr_E), .tnew_E(tnew_E),
        .read1addr_E(read1addr_E), .read2addr_E(read2addr_E),
        .md_start_E(md_start_E), .md_div_E(md_div_E),
        .rfwe_M(rfwe_M), .writeaddr_M(writeaddr_M), .tnew_M(tnew_M),
        .rfwe_W(rfwe_W), .writeaddr_W(writeaddr_W),
        .en_PC(en_PC), .en_D(en_D), .clr_E(clr_E),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
        .md_busy(md_busy)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall;
        logic [1:0] fwd_rs;
        logic [1:0] fwd_rt;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       busy;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  m_cnt   = 4'd0;
    logic [31:0] m_scnt  = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic st, input logic [1:0] frs, input logic [1:0] frt,
                                input logic [1:0] fa, input logic [1:0] fb, input logic bz);
        exp_t e;
        e.stall = st; e.fwd_rs = frs; e.fwd_rt = frt; e.fwd_a = fa; e.fwd_b = fb; e.busy = bz;
        return e;
    endfunction

    function automatic logic hit(input logic we, input logic [4:0] wa, input logic [4:0] a);
        return we && (a != 5'd0) && (wa == a);
    endfunction

    // Reference model of the combinational outputs from the current inputs and model counter
    function automatic exp_t model();
        exp_t e;
        logic s_rs, s_rt, s_md;
        s_rs = (hit(rfwe_E, writeaddr_E, rs_D) && tuse_rs_D < tnew_E) ||
               (hit(rfwe_M, writeaddr_M, rs_D) && tuse_rs_D < tnew_M);
        s_rt = (hit(rfwe_E, writeaddr_E, rt_D) && tuse_rt_D < tnew_E) ||
               (hit(rfwe_M, writeaddr_M, rt_D) && tuse_rt_D < tnew_M);
        s_md = md_use_D && (md_start_E || (m_cnt != 4'd0));
        e.stall = s_rs | s_rt | s_md;
        e.fwd_rs = (hit(rfwe_E, writeaddr_E, rs_D) && tnew_E == 3'd0) ? 2'd1 :
                   (hit(rfwe_M, writeaddr_M, rs_D) && tnew_M == 3'd0) ? 2'd2 : 2'd0;
        e.fwd_rt = (hit(rfwe_E, writeaddr_E, rt_D) && tnew_E == 3'd0) ? 2'd1 :
                   (hit(rfwe_M, writeaddr_M, rt_D) && tnew_M == 3'd0) ? 2'd2 : 2'd0;
        e.fwd_a  = (hit(rfwe_M, writeaddr_M, read1addr_E) && tnew_M == 3'd0) ? 2'd1 :
                   hit(rfwe_W, writeaddr_W, read1addr_E) ? 2'd2 : 2'd0;
        e.fwd_b  = (hit(rfwe_M, writeaddr_M, read2addr_E) && tnew_M == 3'd0) ? 2'd1 :
                   hit(rfwe_W, writeaddr_W, read2addr_E) ? 2'd2 : 2'd0;
        e.busy = (m_cnt != 4'd0);
        return e;
    endfunction

    // Model state: busy countdown and stall counter, advanced on the same edges as the DUT
    always @(posedge clk) begin
        if (reset) begin
            m_cnt  <= 4'd0;
            m_scnt <= 32'd0;
        end else begin
            if (md_start_E)          m_cnt <= md_div_E ? 4'd10 : 4'd5;
            else if (m_cnt != 4'd0)  m_cnt <= m_cnt - 4'd1;
            if (model().stall)       m_scnt <= m_scnt + 32'd1;
        end
    end

    task automatic clr_in();
        rs_D = 0; rt_D = 0; tuse_rs_D = 0; tuse_rt_D = 0; md_use_D = 0;
        rfwe_E = 0; writeaddr_E = 0; tnew_E = 0; read1addr_E = 0; read2addr_E = 0;
        md_start_E = 0; md_div_E = 0;
        rfwe_M = 0; writeaddr_M = 0; tnew_M = 0; rfwe_W = 0; writeaddr_W = 0;
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, ".q"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, ".en_PC"},    en_PC,    !e.stall);
            chk({tag, ".en_D"},     en_D,     !e.stall);
            chk({tag, ".clr_E"},    clr_E,    e.stall);
            chk({tag, ".fwd_rs_D"}, fwd_rs_D, e.fwd_rs);
            chk({tag, ".fwd_rt_D"}, fwd_rt_D, e.fwd_rt);
            chk({tag, ".fwd_a_E"},  fwd_a_E,  e.fwd_a);
            chk({tag, ".fwd_b_E"},  fwd_b_E,  e.fwd_b);
            chk({tag, ".md_busy"},  md_busy,  e.busy);
`ifdef HAZARD_STALL_CNT_EN
            chk({tag, ".stall_cnt"}, stall_cnt, m_scnt);
`endif
        end
    endtask

    // Inputs are already driven; queue the expectation, compare at negedge, advance past next posedge
    task automatic cyc(input string tag, input exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
        check_out(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("rst_hold", mk(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        cyc("rst_idle", mk(0, 0, 0, 0, 0, 0));

        // E producer not ready: stall held for seven cycles
        rs_D = 5; tuse_rs_D = 0; rfwe_E = 1; writeaddr_E = 5; tnew_E = 1;
        for (int i = 0; i < 7; i++) cyc("t1_stall", mk(1, 0, 0, 0, 0, 0));
        clr_in();
        cyc("t1_rel", mk(0, 0, 0, 0, 0, 0));
`ifdef HAZARD_STALL_CNT_EN
        chk("stall_cnt_7", stall_cnt, 32'd7);
        reset = 1'b1;
        cyc("t6_rst", mk(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        chk("stall_cnt_rst", stall_cnt, 32'd0);
`endif

        // Forwarding from E, then from M, and E priority
        rs_D = 5; tuse_rs_D = 0; rfwe_E = 1; writeaddr_E = 5; tnew_E = 0;
        cyc("t2_fwdE", mk(0, 1, 0, 0, 0, 0));
        rfwe_E = 0; rfwe_M = 1; writeaddr_M = 5; tnew_M = 0;
        cyc("t2_fwdM", mk(0, 2, 0, 0, 0, 0));
        rfwe_E = 1;
        cyc("t2_prio", mk(0, 1, 0, 0, 0, 0));
        clr_in();

        // $0 never hits
        rfwe_E = 1; writeaddr_E = 0; rs_D = 0; tnew_E = 2;
        cyc("t3_zero", mk(0, 0, 0, 0, 0, 0));
        clr_in();

        // Tuse vs Tnew boundary on rs (E) and rt (M)
        rs_D = 5; rfwe_E = 1; writeaddr_E = 5; tnew_E = 2; tuse_rs_D = 2;
        cyc("rs_eq", mk(0, 0, 0, 0, 0, 0));
        tuse_rs_D = 1;
        cyc("rs_lt", mk(1, 0, 0, 0, 0, 0));
        rfwe_E = 0;
        cyc("rs_nowe", mk(0, 0, 0, 0, 0, 0));
        clr_in();
        rt_D = 9; rfwe_M = 1; writeaddr_M = 9; tnew_M = 2; tuse_rt_D = 1;
        cyc("rt_lt", mk(1, 0, 0, 0, 0, 0));
        tuse_rt_D = 2;
        cyc("rt_eq", mk(0, 0, 0, 0, 0, 0));
        tuse_rt_D = 7; tnew_M = 0;
        cyc("rt_fwdM", mk(0, 0, 2, 0, 0, 0));
        clr_in();

        // E-stage forwarding: M over W, W only when M not ready
        read1addr_E = 7; rfwe_M = 1; writeaddr_M = 7; tnew_M = 0;
        cyc("a_M", mk(0, 0, 0, 1, 0, 0));
        rfwe_W = 1; writeaddr_W = 7;
        cyc("a_MW", mk(0, 0, 0, 1, 0, 0));
        tnew_M = 1;
        cyc("a_W", mk(0, 0, 0, 2, 0, 0));
        read2addr_E = 7;
        cyc("b_W", mk(0, 0, 0, 2, 2, 0));
        read1addr_E = 0; read2addr_E = 0; writeaddr_W = 0; writeaddr_M = 0;
        cyc("ab_zero", mk(0, 0, 0, 0, 0, 0));
        clr_in();

        // Mult: busy for 5 cycles after start, HI/LO user released on the 6th
        md_start_E = 1; md_use_D = 1;
        cyc("mul_t", mk(1, 0, 0, 0, 0, 0));
        md_start_E = 0;
        for (int i = 1; i <= 5; i++) cyc("mul_busy", mk(1, 0, 0, 0, 0, 1));
        cyc("mul_done", mk(0, 0, 0, 0, 0, 0));

        // Div interrupted by reset at t+3
        md_start_E = 1; md_div_E = 1;
        cyc("div_t", mk(1, 0, 0, 0, 0, 0));
        md_start_E = 0;
        cyc("div_t1", mk(1, 0, 0, 0, 0, 1));
        cyc("div_t2", mk(1, 0, 0, 0, 0, 1));
        reset = 1'b1;
        cyc("div_t3", mk(1, 0, 0, 0, 0, 1));
        reset = 1'b0;
        cyc("div_t4", mk(0, 0, 0, 0, 0, 0));
        cyc("div_t5", mk(0, 0, 0, 0, 0, 0));
        clr_in();

        // Reset beats a simultaneous start
        reset = 1'b1; md_start_E = 1;
        cyc("rst_vs_start", mk(0, 0, 0, 0, 0, 0));
        reset = 1'b0; md_start_E = 0;
        cyc("rst_won", mk(0, 0, 0, 0, 0, 0));

        // Reload: div started while a mult is still counting gets the full 10 cycles
        md_start_E = 1;
        cyc("rl_mul", mk(0, 0, 0, 0, 0, 0));
        md_start_E = 0;
        cyc("rl_t1", mk(0, 0, 0, 0, 0, 1));
        md_start_E = 1; md_div_E = 1;
        cyc("rl_div", mk(0, 0, 0, 0, 0, 1));
        md_start_E = 0; md_div_E = 0;
        for (int i = 0; i < 10; i++) cyc("rl_busy", mk(0, 0, 0, 0, 0, 1));
        cyc("rl_done", mk(0, 0, 0, 0, 0, 0));

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 59) == 0);
            rs_D        = 5'($urandom_range(0, 3));
            rt_D        = 5'($urandom_range(0, 3));
            tuse_rs_D   = 3'($urandom_range(0, 7));
            tuse_rt_D   = 3'($urandom_range(0, 7));
            md_use_D    = ($urandom_range(0, 2) == 0);
            rfwe_E      = 1'($urandom_range(0, 1));
            writeaddr_E = 5'($urandom_range(0, 3));
            tnew_E      = 3'($urandom_range(0, 2));
            read1addr_E = 5'($urandom_range(0, 3));
            read2addr_E = 5'($urandom_range(0, 3));
            md_start_E  = ($urandom_range(0, 11) == 0);
            md_div_E    = 1'($urandom_range(0, 1));
            rfwe_M      = 1'($urandom_range(0, 1));
            writeaddr_M = 5'($urandom_range(0, 3));
            tnew_M      = 3'($urandom_range(0, 1));
            rfwe_W      = 1'($urandom_range(0, 1));
            writeaddr_W = 5'($urandom_range(0, 3));
            cyc("rand", model());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
